// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch state encoding, RAM command codes and reset PC.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    IF1,
    IF2,
    UPDATE,
    WAIT,
    HALT
  } fetch_state_t;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] RESET_PC = 9'd0;

  // 9-bit increment wraps naturally, so 511 rolls over to 0.
  function automatic logic [8:0] pc_next(input logic [8:0] pc);
    return pc + 9'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_vdffe.sv
// Load-enable register with asynchronous active-high reset to a parameterised value.
module vDFFE #(
  parameter int             N       = 1,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: reads one word per instruction from RAM into the IR
// and holds it until decode accepts it, then advances, redirects or halts.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  output logic [8:0]  mem_addr,
  output logic [1:0]  mem_cmd,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [8:0]  redirect_pc,
  input  logic        halt_in,
  output logic [8:0]  pc_out,
  output logic        halted
);

  fetch_state_t state;
  logic         accept;
  logic         pc_en;
  logic [8:0]   pc_d;
  logic         ir_en;

  assign accept = (state == WAIT) && ir_ready;

  // Halt wins over redirect; redirect/halt_in only matter on the accept cycle.
  assign pc_en = (state == UPDATE) || (accept && !halt_in && redirect);
  assign pc_d  = (state == UPDATE) ? pc_next(pc_out) : redirect_pc;
  assign ir_en = (state == IF2);

  vDFFE #(.N(9), .RST_VAL(RESET_PC)) pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_out)
  );

  vDFFE #(.N(16), .RST_VAL(16'h0000)) ir_reg (
    .clk   (clk),
    .reset (reset),
    .en    (ir_en),
    .d     (mem_rdata),
    .q     (ir_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IF1;
    end else begin
      case (state)
        IF1:     state <= IF2;
        IF2:     state <= UPDATE;
        UPDATE:  state <= WAIT;
        WAIT:    if (ir_ready) state <= halt_in ? HALT : IF1;
        HALT:    state <= HALT;
        default: state <= IF1;
      endcase
    end
  end

  // Reset gates the read command directly so RAM sees MNONE without waiting for an edge.
  assign mem_addr = pc_out;
  assign mem_cmd  = (!reset && (state == IF1 || state == IF2)) ? MREAD : MNONE;
  assign ir_valid = (state == WAIT);
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/accept/redirect/halt/reset scenarios
// against a one-cycle-latency RAM model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic [15:0] ir;
    logic [8:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_rdata = 16'h0000;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_cmd;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = 9'd0;
  logic        halt_in = 1'b0;
  logic [8:0]  pc_out;
  logic        halted;

  logic [15:0] ram [0:511];
  exp_t        exp_q [$];
  int          checks_total = 0;
  int          checks_passed = 0;
  logic        prev_valid = 1'b0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_cmd     (mem_cmd),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_in     (halt_in),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // RAM returns data one cycle after a read command.
  always @(posedge clk) begin
    if (mem_cmd == MREAD)
      mem_rdata <= ram[mem_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: each new instruction presented is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (ir_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected ir_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("scoreboard ir_out", {16'h0, ir_out}, {16'h0, e.ir});
          check_output("scoreboard pc_out", {23'h0, pc_out}, {23'h0, e.pc});
        end
      end
      prev_valid = ir_valid;
    end
  end

  task automatic push_exp(input logic [15:0] ir, input logic [8:0] pc);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Counts falling edges until ir_valid shows, bounded so a stuck DUT still terminates.
  task automatic wait_valid(input int n, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ir_valid && k < 20);
    check_output({name, " latency"}, k, n);
  endtask

  // Called at a falling edge in WAIT; returns at the falling edge after the accept edge.
  task automatic apply_stimulus(input logic redir, input logic [8:0] rpc, input logic hlt);
    check_output("ir_valid before accept", {31'h0, ir_valid}, 32'd1);
    ir_ready    = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    halt_in     = hlt;
    @(negedge clk);
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    halt_in     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      ram[i] = 16'h5A00 | 16'(i);
    ram[0]   = 16'hD105;
    ram[1]   = 16'h1111;
    ram[2]   = 16'h2222;
    ram[25]  = 16'hA025;
    ram[511] = 16'hF1FF;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("reset ir_valid", {31'h0, ir_valid}, 32'd0);
    check_output("reset halted",   {31'h0, halted}, 32'd0);
    check_output("reset mem_cmd",  {30'h0, mem_cmd}, {30'h0, MNONE});
    check_output("reset mem_addr", {23'h0, mem_addr}, {23'h0, RESET_PC});
    check_output("reset pc_out",   {23'h0, pc_out}, {23'h0, RESET_PC});
    check_output("reset ir_out",   {16'h0, ir_out}, 32'h0);

    // First fetch after reset release
    reset = 1'b0;
    push_exp(16'hD105, 9'd1);
    #1;
    check_output("IF1 mem_cmd", {30'h0, mem_cmd}, {30'h0, MREAD});
    check_output("IF1 mem_addr", {23'h0, mem_addr}, 32'd0);
    wait_valid(3, "reset-to-valid");

    // Stall in WAIT with stray redirect/halt that must be ignored
    for (int i = 0; i < 5; i++) begin
      redirect    = 1'b1;
      redirect_pc = 9'd300;
      halt_in     = 1'b1;
      @(negedge clk);
      check_output("stall ir_valid", {31'h0, ir_valid}, 32'd1);
      check_output("stall ir_out",   {16'h0, ir_out}, 32'hD105);
      check_output("stall pc_out",   {23'h0, pc_out}, 32'd1);
      check_output("stall mem_cmd",  {30'h0, mem_cmd}, {30'h0, MNONE});
    end
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    halt_in     = 1'b0;

    // Plain sequential accept
    push_exp(16'h1111, 9'd2);
    apply_stimulus(1'b0, 9'd0, 1'b0);
    check_output("seq IF1 mem_addr", {23'h0, mem_addr}, 32'd1);
    wait_valid(3, "accept-to-valid");

    // Redirect to 25; later pulses in IF2 are ignored
    push_exp(16'hA025, 9'd26);
    apply_stimulus(1'b1, 9'd25, 1'b0);
    check_output("redirect IF1 mem_addr", {23'h0, mem_addr}, 32'd25);
    check_output("redirect IF1 mem_cmd",  {30'h0, mem_cmd}, {30'h0, MREAD});
    @(negedge clk);
    check_output("redirect IF2 mem_addr", {23'h0, mem_addr}, 32'd25);
    check_output("redirect IF2 mem_cmd",  {30'h0, mem_cmd}, {30'h0, MREAD});
    ir_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 9'd100;
    halt_in     = 1'b1;
    @(negedge clk);
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    halt_in     = 1'b0;
    check_output("UPDATE mem_cmd", {30'h0, mem_cmd}, {30'h0, MNONE});
    wait_valid(1, "update-to-valid");

    // PC wrap from 511 to 0
    push_exp(16'hF1FF, 9'd0);
    apply_stimulus(1'b1, 9'd511, 1'b0);
    check_output("wrap IF1 mem_addr", {23'h0, mem_addr}, 32'd511);
    wait_valid(3, "wrap fetch");
    push_exp(16'hD105, 9'd1);
    apply_stimulus(1'b0, 9'd0, 1'b0);
    check_output("post-wrap mem_addr", {23'h0, mem_addr}, 32'd0);
    check_output("post-wrap mem_cmd",  {30'h0, mem_cmd}, {30'h0, MREAD});
    wait_valid(3, "post-wrap fetch");

    // Halt has priority over redirect
    apply_stimulus(1'b1, 9'd77, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_output("halt halted",   {31'h0, halted}, 32'd1);
      check_output("halt ir_valid", {31'h0, ir_valid}, 32'd0);
      check_output("halt mem_cmd",  {30'h0, mem_cmd}, {30'h0, MNONE});
      check_output("halt pc_out",   {23'h0, pc_out}, 32'd1);
      ir_ready    = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 9'd5;
      @(negedge clk);
    end
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 9'd0;
    #2 reset = 1'b1;
    #1;
    check_output("halt reset halted",  {31'h0, halted}, 32'd0);
    check_output("halt reset pc_out",  {23'h0, pc_out}, {23'h0, RESET_PC});
    check_output("halt reset mem_cmd", {30'h0, mem_cmd}, {30'h0, MNONE});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_exp(16'hD105, 9'd1);
    wait_valid(3, "restart after halt");

    // Reset during IF2 discards the in-flight fetch of address 1
    apply_stimulus(1'b0, 9'd0, 1'b0);
    check_output("abort IF1 mem_addr", {23'h0, mem_addr}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort ir_valid", {31'h0, ir_valid}, 32'd0);
    check_output("abort mem_cmd",  {30'h0, mem_cmd}, {30'h0, MNONE});
    check_output("abort mem_addr", {23'h0, mem_addr}, {23'h0, RESET_PC});
    check_output("abort ir_out",   {16'h0, ir_out}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_exp(16'hD105, 9'd1);
    #1;
    check_output("restart mem_addr", {23'h0, mem_addr}, {23'h0, RESET_PC});
    check_output("restart mem_cmd",  {30'h0, mem_cmd}, {30'h0, MREAD});
    wait_valid(3, "restart after abort");

    repeat (2) @(negedge clk);
    check_output("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 9'd0, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 mem_rdata  input  16  read data from instruction/data RAM; valid one cycle after mem_addr/mem_cmd present MREAD.
REQ-005 mem_addr  output  9  word address to RAM.
REQ-006 mem_cmd  output  2  memory command: MNONE, MREAD (MWRITE never driven by this block).
REQ-007 ir_out  output  16  fetched instruction.
REQ-008 ir_valid  output  1  ir_out holds an unconsumed instruction.
REQ-009 ir_ready  input  1  downstream decode/execute accepts ir_out this cycle.
REQ-010 redirect  input  1  branch/jump taken; qualified by the accept cycle.
REQ-011 redirect_pc  input  9  branch target.
REQ-012 halt_in  input  1  accepted instruction is HALT.
REQ-013 pc_out  output  9  current PC (address of the next instruction after UPDATE).
REQ-014 halted  output  1  fetch stopped by HALT; drives board LEDR[8].

Function
REQ-015 States: IF1, IF2, UPDATE, WAIT, HALT.
REQ-016 IF1: mem_addr=pc, mem_cmd=MREAD; next IF2.
REQ-017 IF2: mem_addr and mem_cmd held as in IF1; ir <= mem_rdata at the clock edge leaving IF2; next UPDATE.
REQ-018 UPDATE: pc <= pc+1, modulo 512 (9'd511 wraps to 9'd0); mem_cmd=MNONE; next WAIT.
REQ-019 WAIT: ir_valid=1, mem_cmd=MNONE; ir_out stable until ir_ready=1.
REQ-020 Accept = WAIT && ir_ready; on accept with halt_in=1 go HALT (halt_in has priority over redirect); else if redirect=1 pc <= redirect_pc and go IF1; else go IF1 with pc unchanged.
REQ-021 redirect, redirect_pc, halt_in are ignored in every cycle other than an accept cycle.
REQ-022 HALT: halted=1, ir_valid=0, mem_cmd=MNONE, pc frozen; HALT is exited only by reset.
REQ-023 Latency: reset release to ir_valid=1 is 3 rising edges; accept to the next ir_valid=1 is 4 edges.
REQ-024 ir_valid=0 and mem_cmd=MNONE in every state except as stated in REQ-016, REQ-017 and REQ-019.

Reset
REQ-025 On reset: state=IF1, pc=RESET_PC, ir=16'h0000, ir_valid=0, halted=0.
REQ-026 While reset is high: mem_cmd=MNONE and mem_addr=RESET_PC.
REQ-027 Reset asserted mid-fetch or in HALT discards any in-flight instruction; no ir_valid pulse occurs after reset release until REQ-023 timing elapses.

Structure
REQ-028 The state encoding and the MNONE/MREAD/MWRITE command codes belong in the shared CPU package used by the controller and RAM.
REQ-029 The PC and IR are instances of the existing load-enable register sub-module vDFFE; the state machine is local.

Verification
REQ-030 Reset with RAM[0]=16'hD105, ir_ready=1 -> ir_out=16'hD105 and ir_valid=1 at the 3rd edge after release; pc_out=1.
REQ-031 ir_ready held 0 for 5 cycles in WAIT -> ir_valid stays 1, ir_out and pc_out unchanged, mem_cmd=MNONE throughout.
REQ-032 Accept with redirect=1 and redirect_pc=9'd25 -> next IF1 shows mem_addr=25, MREAD; redirect pulsed in IF2 has no effect.
REQ-033 PC at 9'd511 -> after UPDATE pc_out=0; next fetch reads address 0.
REQ-034 Accept with halt_in=1 and redirect=1 -> HALT, halted=1, pc unchanged, no further MREAD; reset -> IF1 with pc=RESET_PC and halted=0.
REQ-035 Reset asserted during IF2 -> ir_valid=0 and mem_cmd=MNONE immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
